// File: rtl/data_mem_access_ctrl.sv
// ============================================================================
// data_mem_access_ctrl
// ----------------------------------------------------------------------------
// Front end between the CPU memory stage and the data-memory block RAM
// wrapper. One load or store is accepted per valid/ready handshake. The
// address, data and enables are registered into the RAM, the RAM's fixed read
// latency is absorbed, and the result comes back on a response channel that
// holds until it is consumed. Word addresses beyond the implemented RAM depth
// are answered with a fault and never touch the RAM.
//
// Parameters
//   ADDR_W     implemented word-address bits (RAM depth = 2^ADDR_W words)
//   RD_LAT     RAM read latency in cycles (1 or 2)
//
// Ports
//   Clock      system clock, rising edge
//   Reset      synchronous, active-low reset
//   Req_Valid  request present             Req_Ready   request accepted now
//   Req_Write  1 = store, 0 = load         Req_Addr    word address
//   Req_WData  store data
//   Resp_Valid response present (held)     Resp_Ready  consumer takes it
//   Resp_RData load data (0 otherwise)     Resp_Fault  address out of range
//   Mem_Addr   RAM word address            Mem_En_W    RAM write enable
//   Mem_En_R   RAM read enable             Mem_Data_W  RAM write data
//   Mem_Data_R RAM read data
// ============================================================================
module data_mem_access_ctrl #(
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 1
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Req_Valid,
   output logic        Req_Ready,
   input  logic        Req_Write,
   input  logic [29:0] Req_Addr,
   input  logic [31:0] Req_WData,
   output logic        Resp_Valid,
   input  logic        Resp_Ready,
   output logic [31:0] Resp_RData,
   output logic        Resp_Fault,
   output logic [29:0] Mem_Addr,
   output logic        Mem_En_W,
   output logic        Mem_En_R,
   output logic [31:0] Mem_Data_W,
   input  logic [31:0] Mem_Data_R
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      state_q,     state_d;
   logic [1:0]  latCnt_q,    latCnt_d;
   logic        respValid_q, respValid_d;
   logic [31:0] respRData_q, respRData_d;
   logic        respFault_q, respFault_d;
   logic [29:0] memAddr_q,   memAddr_d;
   logic        memEnW_q,    memEnW_d;
   logic        memEnR_q,    memEnR_d;
   logic [31:0] memDataW_q,  memDataW_d;

   logic accept;
   logic inRange;

   // Ready is the only combinational output; it is forced low during reset so
   // nothing is handshaken on a cycle whose state is about to be discarded.
   assign Req_Ready = (state_q == IDLE) && Reset;
   assign accept    = Req_Valid && Req_Ready;

   // Any address bit above the implemented RAM depth marks the request as a
   // fault.
   assign inRange = (Req_Addr >> ADDR_W) == 30'd0;

   // State and output registers. Reset clears everything, which also drops
   // any in-flight request without producing a response for it.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q     <= IDLE;
         latCnt_q    <= '0;
         respValid_q <= 1'b0;
         respRData_q <= '0;
         respFault_q <= 1'b0;
         memAddr_q   <= '0;
         memEnW_q    <= 1'b0;
         memEnR_q    <= 1'b0;
         memDataW_q  <= '0;
      end else begin
         state_q     <= state_d;
         latCnt_q    <= latCnt_d;
         respValid_q <= respValid_d;
         respRData_q <= respRData_d;
         respFault_q <= respFault_d;
         memAddr_q   <= memAddr_d;
         memEnW_q    <= memEnW_d;
         memEnR_q    <= memEnR_d;
         memDataW_q  <= memDataW_d;
      end
   end

   // Next-state logic. The RAM enables default to 0 so each one is a single
   // cycle pulse during ISSUE; address and write data otherwise hold their last
   // values, because only the enables qualify them. The enable registered on
   // accept doubles as the captured store/load flag once in ISSUE.
   always_comb begin
      state_d     = state_q;
      latCnt_d    = latCnt_q;
      respValid_d = respValid_q;
      respRData_d = respRData_q;
      respFault_d = respFault_q;
      memAddr_d   = memAddr_q;
      memEnW_d    = 1'b0;
      memEnR_d    = 1'b0;
      memDataW_d  = memDataW_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (inRange) begin
                  state_d   = ISSUE;
                  memAddr_d = Req_Addr;
                  if (Req_Write) begin
                     memEnW_d   = 1'b1;
                     memDataW_d = Req_WData;
                  end else begin
                     memEnR_d = 1'b1;
                  end
               end else begin
                  state_d     = RESP;
                  respValid_d = 1'b1;
                  respFault_d = 1'b1;
                  respRData_d = '0;
               end
            end
         end

         ISSUE: begin
            if (memEnW_q) begin
               state_d     = RESP;
               respValid_d = 1'b1;
               respFault_d = 1'b0;
               respRData_d = '0;
            end else begin
               state_d  = WAIT;
               latCnt_d = 2'(RD_LAT);
            end
         end

         // The counter reaches 1 in exactly the cycle the RAM's read data is
         // valid, which is when it gets captured into the response.
         WAIT: begin
            if (latCnt_q == 2'd1) begin
               state_d     = RESP;
               latCnt_d    = '0;
               respValid_d = 1'b1;
               respFault_d = 1'b0;
               respRData_d = Mem_Data_R;
            end else begin
               latCnt_d = latCnt_q - 2'd1;
            end
         end

         RESP: begin
            if (Resp_Ready) begin
               state_d     = IDLE;
               respValid_d = 1'b0;
               respFault_d = 1'b0;
               respRData_d = '0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign Resp_Valid = respValid_q;
   assign Resp_RData = respRData_q;
   assign Resp_Fault = respFault_q;
   assign Mem_Addr   = memAddr_q;
   assign Mem_En_W   = memEnW_q;
   assign Mem_En_R   = memEnR_q;
   assign Mem_Data_W = memDataW_q;

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// ============================================================================
// tb_data_mem_access_ctrl
// ----------------------------------------------------------------------------
// Two controller instances, one built with RD_LAT=1 and one with RD_LAT=2,
// each attached to its own behavioural RAM whose read data is only valid in
// the cycle the latency says it should be. A vector table and randomized
// traffic are checked against a shadow memory plus latency rules; reset and
// mid-load reset are driven as hand-written sequences.
// ============================================================================
module tb_data_mem_access_ctrl;

   localparam int LAT0 = 1;
   localparam int LAT1 = 2;

   logic        clock;
   logic        resetN     [2];
   logic        reqValid   [2];
   logic        reqReady   [2];
   logic        reqWrite   [2];
   logic [29:0] reqAddr    [2];
   logic [31:0] reqWData   [2];
   logic        respValid  [2];
   logic        respReady  [2];
   logic [31:0] respRData  [2];
   logic        respFault  [2];
   logic [29:0] memAddr    [2];
   logic        memEnW     [2];
   logic        memEnR     [2];
   logic [31:0] memDataW   [2];
   logic [31:0] memDataR   [2];

   int errors;
   int checks;

   data_mem_access_ctrl #(.ADDR_W(10), .RD_LAT(LAT0)) dut0 (
      .Clock(clock), .Reset(resetN[0]),
      .Req_Valid(reqValid[0]), .Req_Ready(reqReady[0]), .Req_Write(reqWrite[0]),
      .Req_Addr(reqAddr[0]), .Req_WData(reqWData[0]),
      .Resp_Valid(respValid[0]), .Resp_Ready(respReady[0]),
      .Resp_RData(respRData[0]), .Resp_Fault(respFault[0]),
      .Mem_Addr(memAddr[0]), .Mem_En_W(memEnW[0]), .Mem_En_R(memEnR[0]),
      .Mem_Data_W(memDataW[0]), .Mem_Data_R(memDataR[0])
   );

   data_mem_access_ctrl #(.ADDR_W(10), .RD_LAT(LAT1)) dut1 (
      .Clock(clock), .Reset(resetN[1]),
      .Req_Valid(reqValid[1]), .Req_Ready(reqReady[1]), .Req_Write(reqWrite[1]),
      .Req_Addr(reqAddr[1]), .Req_WData(reqWData[1]),
      .Resp_Valid(respValid[1]), .Resp_Ready(respReady[1]),
      .Resp_RData(respRData[1]), .Resp_Fault(respFault[1]),
      .Mem_Addr(memAddr[1]), .Mem_En_W(memEnW[1]), .Mem_En_R(memEnR[1]),
      .Mem_Data_W(memDataW[1]), .Mem_Data_R(memDataR[1])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural RAMs: a read pipeline whose data shows up exactly RD_LAT
   // cycles after the read enable and reads as a poison value at any other time.
   logic [31:0] ram    [2][1024];
   logic        p1Valid[2];
   logic        p2Valid[2];
   logic [31:0] p1Data [2];
   logic [31:0] p2Data [2];

   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 1024; i++) ram[d][i] = 32'h0;
         p1Valid[d] = 1'b0;
         p2Valid[d] = 1'b0;
         p1Data[d]  = 32'h0;
         p2Data[d]  = 32'h0;
      end
   end

   always @(posedge clock) begin
      for (int d = 0; d < 2; d++) begin
         if (memEnW[d]) ram[d][memAddr[d][9:0]] <= memDataW[d];
         p1Valid[d] <= memEnR[d];
         p1Data[d]  <= ram[d][memAddr[d][9:0]];
         p2Valid[d] <= p1Valid[d];
         p2Data[d]  <= p1Data[d];
      end
   end

   assign memDataR[0] = p1Valid[0] ? p1Data[0] : 32'hBADBAD00;
   assign memDataR[1] = p2Valid[1] ? p2Data[1] : 32'hBADBAD11;

   // Reference model: shadow memory contents and the latency rules.
   logic [31:0] shadow[2][1024];

   function automatic int expLatency(input int d, input bit wr, input bit flt);
      if (flt) return 1;
      if (wr) return 2;
      return 2 + ((d == 0) ? LAT0 : LAT1);
   endfunction

   function automatic bit isFault(input logic [29:0] addr);
      return (addr >> 10) != 30'd0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drives one request into instance d and watches it until its response.
   // Bus activity per cycle is summarised into counts; after the response
   // is seen, Resp_Ready is held low for 'hold' cycles to exercise
   // backpressure, and the consume cycle is checked.
   task automatic applyStimulus(input int d, input bit wr, input logic [29:0] addr,
                                input logic [31:0] wdata, input int hold,
                                output logic [31:0] rdata, output logic fault,
                                output int lat, output int nW, output int nR,
                                output int nBad, output int enCyc);
      bit got;
      @(negedge clock);
      respReady[d] = (hold == 0);
      reqValid[d]  = 1'b1;
      reqWrite[d]  = wr;
      reqAddr[d]   = addr;
      reqWData[d]  = wdata;
      checkOutput($sformatf("d%0d_ready_before_accept", d), 32'(reqReady[d]), 32'd1);
      @(posedge clock);
      got = 1'b0; lat = -1; nW = 0; nR = 0; nBad = 0; enCyc = 0;
      rdata = 32'hFFFF_FFFF; fault = 1'bx;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(negedge clock);
         // Keep a garbage request asserted while busy; it must be ignored.
         reqWrite[d] = 1'($urandom);
         reqAddr[d]  = 30'($urandom);
         reqWData[d] = $urandom;
         if (memEnW[d] && memEnR[d]) nBad++;
         if (memEnW[d]) begin
            nW++;
            if (enCyc == 0) enCyc = c;
            if (memAddr[d] !== addr || memDataW[d] !== wdata) nBad++;
         end
         if (memEnR[d]) begin
            nR++;
            if (enCyc == 0) enCyc = c;
            if (memAddr[d] !== addr) nBad++;
         end
         if (respValid[d]) begin
            got   = 1'b1;
            lat   = c;
            rdata = respRData[d];
            fault = respFault[d];
            reqValid[d] = 1'b0;
         end
      end
      reqValid[d] = 1'b0;
      if (got) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            checkOutput($sformatf("d%0d_bp_valid", d), 32'(respValid[d]), 32'd1);
            checkOutput($sformatf("d%0d_bp_rdata", d), respRData[d], rdata);
            checkOutput($sformatf("d%0d_bp_fault", d), 32'(respFault[d]), 32'(fault));
            checkOutput($sformatf("d%0d_bp_ready", d), 32'(reqReady[d]), 32'd0);
         end
      end
      respReady[d] = 1'b1;
      @(negedge clock);
      checkOutput($sformatf("d%0d_consumed_valid", d), 32'(respValid[d]), 32'd0);
      checkOutput($sformatf("d%0d_consumed_ready", d), 32'(reqReady[d]), 32'd1);
   endtask

   // Runs one transaction and compares everything against the model.
   task automatic runCheck(input int d, input string tag, input bit wr,
                           input logic [29:0] addr, input logic [31:0] wdata,
                           input int hold, input logic [31:0] expRData);
      logic [31:0] rdata;
      logic        fault;
      int          lat, nW, nR, nBad, enCyc;
      bit          flt;
      flt = isFault(addr);
      applyStimulus(d, wr, addr, wdata, hold, rdata, fault, lat, nW, nR, nBad, enCyc);
      checkOutput($sformatf("d%0d_%s_latency", d, tag), 32'(lat), 32'(expLatency(d, wr, flt)));
      checkOutput($sformatf("d%0d_%s_rdata", d, tag), rdata, expRData);
      checkOutput($sformatf("d%0d_%s_fault", d, tag), 32'(fault), 32'(flt));
      checkOutput($sformatf("d%0d_%s_wr_enables", d, tag), 32'(nW), 32'((wr && !flt) ? 1 : 0));
      checkOutput($sformatf("d%0d_%s_rd_enables", d, tag), 32'(nR), 32'((!wr && !flt) ? 1 : 0));
      checkOutput($sformatf("d%0d_%s_en_cycle", d, tag), 32'(enCyc), 32'(flt ? 0 : 1));
      checkOutput($sformatf("d%0d_%s_bus_errors", d, tag), 32'(nBad), 32'd0);
      if (wr && !flt) shadow[d][addr[9:0]] = wdata;
   endtask

   typedef struct {
      bit          wr;
      logic [29:0] addr;
      logic [31:0] wdata;
      int          hold;
      logic [31:0] expRData;
   } vec_t;

   vec_t vecs[10];

   initial begin
      bit          rWr;
      logic [29:0] rAddr;
      logic [31:0] rData;
      logic [31:0] rExp;
      int          bad;

      errors = 0;
      checks = 0;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 1024; i++) shadow[d][i] = 32'h0;

      vecs[0] = '{1'b1, 30'h005,      32'hDEADBEEF, 0, 32'h0};
      vecs[1] = '{1'b0, 30'h005,      32'h0,        0, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 30'h400,      32'h0,        0, 32'h0};
      vecs[3] = '{1'b1, 30'h3FF,      32'h12345678, 0, 32'h0};
      vecs[4] = '{1'b0, 30'h3FF,      32'h0,        5, 32'h12345678};
      vecs[5] = '{1'b1, 30'h400,      32'hCAFEF00D, 1, 32'h0};
      vecs[6] = '{1'b0, 30'h000,      32'h0,        0, 32'h0};
      vecs[7] = '{1'b0, 30'h3FFFFFFF, 32'h0,        0, 32'h0};
      vecs[8] = '{1'b1, 30'h000,      32'hA5A55A5A, 2, 32'h0};
      vecs[9] = '{1'b0, 30'h000,      32'h0,        0, 32'hA5A55A5A};

      // Reset held for three cycles with a request pending.
      for (int d = 0; d < 2; d++) begin
         resetN[d]    = 1'b0;
         reqValid[d]  = 1'b1;
         reqWrite[d]  = 1'b1;
         reqAddr[d]   = 30'h005;
         reqWData[d]  = 32'h11111111;
         respReady[d] = 1'b1;
      end
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clock);
         for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("d%0d_rst_ready", d), 32'(reqReady[d]), 32'd0);
            checkOutput($sformatf("d%0d_rst_en_w", d), 32'(memEnW[d]), 32'd0);
            checkOutput($sformatf("d%0d_rst_en_r", d), 32'(memEnR[d]), 32'd0);
            checkOutput($sformatf("d%0d_rst_valid", d), 32'(respValid[d]), 32'd0);
         end
      end
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("d%0d_rst_rdata", d), respRData[d], 32'h0);
         checkOutput($sformatf("d%0d_rst_fault", d), 32'(respFault[d]), 32'd0);
         checkOutput($sformatf("d%0d_rst_addr", d), 32'(memAddr[d]), 32'h0);
         checkOutput($sformatf("d%0d_rst_wdata", d), memDataW[d], 32'h0);
         reqValid[d] = 1'b0;
         resetN[d]   = 1'b1;
      end
      #1;
      for (int d = 0; d < 2; d++)
         checkOutput($sformatf("d%0d_ready_after_release", d), 32'(reqReady[d]), 32'd1);

      // Directed vector table.
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 10; i++)
            runCheck(d, $sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr,
                     vecs[i].wdata, vecs[i].hold, vecs[i].expRData);

      // Randomized traffic against the shadow memory.
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 30; n++) begin
            rWr = 1'($urandom);
            case ($urandom_range(0, 5))
               0:       rAddr = 30'($urandom) | 30'h400;
               1, 2:    rAddr = 30'($urandom_range(0, 1023));
               default: rAddr = 30'($urandom_range(0, 15));
            endcase
            rData = $urandom;
            rExp  = (rWr || isFault(rAddr)) ? 32'h0 : shadow[d][rAddr[9:0]];
            runCheck(d, $sformatf("rnd%0d", n), rWr, rAddr, rData,
                     $urandom_range(0, 2), rExp);
         end
      end

      // Reset while a load is waiting on the RAM: the load must vanish.
      for (int d = 0; d < 2; d++) begin
         @(negedge clock);
         reqValid[d] = 1'b1;
         reqWrite[d] = 1'b0;
         reqAddr[d]  = 30'h007;
         @(posedge clock);
         @(negedge clock);
         reqValid[d] = 1'b0;
         @(negedge clock);
         resetN[d] = 1'b0;
         @(negedge clock);
         resetN[d] = 1'b1;
         bad = 0;
         for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (respValid[d] !== 1'b0 || memEnR[d] !== 1'b0 || memEnW[d] !== 1'b0) bad++;
         end
         checkOutput($sformatf("d%0d_midrst_no_resp", d), 32'(bad), 32'd0);
         checkOutput($sformatf("d%0d_midrst_ready", d), 32'(reqReady[d]), 32'd1);
         runCheck(d, "post_rst_load", 1'b0, 30'h005, 32'h0, 0, shadow[d][10'h005]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
